// File: rtl/regdump_pkg.sv
// Shared types and defaults for the register-file dump reader.
// Header bytes per register are enabled with the REGDUMP_HEADER_EN macro.
package regdump_pkg;

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_ADDR_W   = 5;
  localparam int DEFAULT_DATA_W   = 32;
  localparam int BYTES_PER_WORD   = DEFAULT_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND_HDR,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one snapshotted register word and shifts it out MSB byte first.
// last_byte flags that the byte currently offered is the final one of the word.
module word_byte_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              advance,
  output logic [7:0]        byte_out,
  output logic              last_byte
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_W-1:0] word;
  logic [CNT_W-1:0]  byte_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      word     <= load_data;
      byte_cnt <= '0;
    end else if (advance) begin
      word     <= word << 8;
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign byte_out  = word[DATA_W-1 -: 8];
  assign last_byte = (byte_cnt == CNT_W'(BPW - 1));

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks register indices through a spare async read port and streams every word
// MSB byte first on a valid/ready byte port. REGDUMP_HEADER_EN prefixes each word with its index.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output state_t            dbg_state
);

  // Byte handshake: a byte moves on a posedge where out_valid && out_ready; once raised,
  // out_valid and out_data hold until that transfer (only rst can withdraw them).

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ser_load, ser_advance, ser_last;
  logic [7:0]        ser_byte;

  word_byte_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (rf_rd),
    .advance   (ser_advance),
    .byte_out  (ser_byte),
    .last_byte (ser_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ser_load    = 1'b0;
    ser_advance = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        ser_load = 1'b1;
`ifdef REGDUMP_HEADER_EN
        state_d  = SEND_HDR;
`else
        state_d  = SEND;
`endif
      end
`ifdef REGDUMP_HEADER_EN
      SEND_HDR: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = 8'(idx_q);
        if (out_ready) state_d = SEND;
      end
`endif
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = ser_byte;
        if (out_ready) begin
          ser_advance = 1'b1;
          if (ser_last) begin
            // The index that reaches the last register ends the dump; idx never wraps.
            if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = LOAD;
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rf_ra     = idx_q;
  assign dbg_state = state_q;

endmodule
